// File: rtl/wi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wi_pkg
//  Description : Shared types, default dimensions and helpers for the Wi
//                weight-ROM fetch scheduler.
//  Contents    : state_t        - scheduler FSM states
//                *_DEF          - default NREQ / AW / DW / ROM_LAT values
//                len_decode()   - burst-length decode, 0 means 2**aw beats
//  Revision    : 1.0  initial release
// ============================================================================
package wi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int NREQ_DEF    = 4;
    localparam int AW_DEF      = 8;
    localparam int DW_DEF      = 8;
    localparam int ROM_LAT_DEF = 1;

    // Widest address the length helper handles; callers use AW <= LEN_MAX_W.
    localparam int LEN_MAX_W = 16;

    // A zero length field encodes a full sweep of the ROM (2**aw beats),
    // so the result is one bit wider than the field.
    function automatic logic [LEN_MAX_W:0] len_decode(input logic [LEN_MAX_W-1:0] len,
                                                      input int unsigned aw);
        logic [LEN_MAX_W:0] res;
        if (len == '0)
            res = (LEN_MAX_W+1)'(1) << aw;
        else
            res = {1'b0, len};
        return res;
    endfunction

endpackage : wi_pkg
`default_nettype wire

// File: rtl/wi_fetch_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Selects the first set
//                request at or after the pointer, wrapping around.
//  Ports       : req   in  NREQ  request vector
//                ptr   in  PW    highest-priority requester index
//                en    in  1     arbitration enable; grant is zero when low
//                grant out NREQ  one-hot winner (or zero)
//                idx   out PW    winner index (0 when no winner)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx
);

    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            // Candidate index (ptr + i) mod NREQ; ptr is always < NREQ so a
            // single conditional subtract is enough.
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ))
                sum = sum - (PW+1)'(NREQ);
            cand = sum[PW-1:0];
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/wi_fetch_sched.sv
`default_nettype none
// ============================================================================
//  Module      : wi_fetch_sched
//  Description : Time-shares the Wi weight ROM among NREQ requesters. A
//                round-robin winner gets a burst of consecutive ROM reads;
//                returned weights are streamed back tagged with beat index,
//                last flag and a completion pulse.
//  Ports       : CS        in   clock (rising edge)
//                cen       in   asynchronous active-low reset
//                req       in   per-requester request level
//                req_base  in   start address, slice i for requester i
//                req_len   in   burst length, slice i (0 = 2**AW)
//                grant     out  one-hot owner of current burst
//                busy      out  burst in progress
//                rom_add   out  registered ROM address
//                rom_data  in   ROM read data
//                wt_valid  out  wt_data / wt_idx / wt_last valid
//                wt_data   out  weight (rom_data passed through)
//                wt_idx    out  beat index within burst
//                wt_last   out  final beat of burst
//                done      out  one-cycle burst-complete pulse
//  Revision    : 1.0  initial release
// ============================================================================
module wi_fetch_sched
    import wi_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic              CS,
    input  logic              cen,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] req_base,
    input  logic [NREQ*AW-1:0] req_len,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [AW-1:0]     rom_add,
    input  logic [DW-1:0]     rom_data,
    output logic              wt_valid,
    output logic [DW-1:0]     wt_data,
    output logic [AW-1:0]     wt_idx,
    output logic              wt_last,
    output logic              done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] arb_grant;
    logic [PW-1:0]   arb_idx;
    logic            arb_hit;

    logic [AW:0]     remaining;   // beats still to issue, up to 2**AW
    logic [AW-1:0]   beat;        // index of the address currently issued
    logic            issue;
    logic            issue_last;

    logic [ROM_LAT-1:0] vld_pipe;
    logic [ROM_LAT-1:0] last_pipe;
    logic [AW-1:0]      idx_pipe [ROM_LAT];

    logic [AW-1:0]   sel_base;
    logic [AW-1:0]   sel_len;

    // ------------------------------------------------------------------
    // Arbitration: only meaningful while idle
    // ------------------------------------------------------------------
    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .en    (state == IDLE),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign arb_hit  = |arb_grant;
    assign sel_base = req_base[arb_idx*AW +: AW];
    assign sel_len  = req_len [arb_idx*AW +: AW];

    assign issue      = (state == ISSUE);
    assign issue_last = issue && (remaining == (AW+1)'(1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CS or negedge cen) begin
        if (!cen)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (arb_hit)              state_nxt = ISSUE;
            ISSUE:   if (issue_last)           state_nxt = DRAIN;
            // Leave once the final beat is on the output; done follows.
            DRAIN:   if (wt_last)              state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Burst datapath: grant, address counter, beat counter, pointer
    // ------------------------------------------------------------------
    always_ff @(posedge CS or negedge cen) begin
        if (!cen) begin
            grant     <= '0;
            rom_add   <= '0;
            remaining <= '0;
            beat      <= '0;
            ptr       <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (arb_hit) begin
                        grant     <= arb_grant;
                        rom_add   <= sel_base;
                        remaining <= (AW+1)'(len_decode(LEN_MAX_W'(sel_len), AW));
                        beat      <= '0;
                        ptr       <= (arb_idx == PW'(NREQ-1)) ? '0 : arb_idx + PW'(1);
                    end
                end
                ISSUE: begin
                    remaining <= remaining - (AW+1)'(1);
                    beat      <= beat + AW'(1);
                    // Hold the final address rather than running one past
                    // the burst; rom_add then stays put through idle.
                    if (!issue_last)
                        rom_add <= rom_add + AW'(1);
                end
                DRAIN: begin
                    if (wt_last) begin
                        grant <= '0;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Return-path alignment: the issue strobe and its tags are delayed by
    // the ROM read latency so they line up with rom_data.
    // ------------------------------------------------------------------
    always_ff @(posedge CS or negedge cen) begin
        if (!cen) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            for (int s = 0; s < ROM_LAT; s++)
                idx_pipe[s] <= '0;
        end else begin
            vld_pipe[0]  <= issue;
            last_pipe[0] <= issue_last;
            idx_pipe[0]  <= issue ? beat : '0;
            for (int s = 1; s < ROM_LAT; s++) begin
                vld_pipe[s]  <= vld_pipe[s-1];
                last_pipe[s] <= last_pipe[s-1];
                idx_pipe[s]  <= idx_pipe[s-1];
            end
        end
    end

    assign wt_valid = vld_pipe[ROM_LAT-1];
    assign wt_last  = last_pipe[ROM_LAT-1];
    assign wt_idx   = idx_pipe[ROM_LAT-1];
    assign wt_data  = rom_data;
    assign busy     = |grant;

endmodule : wi_fetch_sched
`default_nettype wire
